hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Pipeline hazard and stall controller for the 5-stage RISC-V core (F/D/E/M/W).
- Produces the stall, flush and forwarding controls that the control-path and datapath pipeline registers consume; its FlushE output drives the controller's ID/EX clear.
- Adds a data-memory wait-state FSM with a timeout and error trap.
- Holds saturating stall and flush performance counters.

Parameters:
- TIMEOUT, 16: max MEM_WAIT cycles before the error trap (>=1).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- Rs1D, Rs2D  in  5 each  source registers in Decode.
- Rs1E, Rs2E, RdE  in  5 each  source and dest registers in Execute.
- RdM, RdW  in  5 each  dest register in Memory and Writeback.
- ResultSrcE0  in  1  Execute instruction is a load.
- PCSrcE  in  1  branch taken or jump in Execute.
- RegWriteM, RegWriteW  in  1 each  register write enables in M and W.
- MemReqM  in  1  load/store access active in Memory.
- MemReadyM  in  1  data memory completes access this cycle.
- StallF, StallD, StallE, StallM  out  1 each  hold the stage register.
- FlushD, FlushE  out  1 each  clear the D / E stage register.
- ForwardAE, ForwardBE  out  2 each  00 = regfile, 01 = W result, 10 = M ALU result.
- MemErr  out  1  sticky memory-timeout error.
- StallCycles  out  CNT_W  cycles with StallF=1.
- FlushCount  out  CNT_W  cycles with FlushD=1.

Behaviour:
- Forwarding (combinational), ForwardAE:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E;
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E;
  - else 00.
  - ForwardBE is identical using Rs2E. M has priority over W.
- Intermediate terms:
  - lwStall = ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
  - memStall = (state==RUN | state==MEM_WAIT) & MemReqM & ~MemReadyM.
- FSM states: RUN, MEM_WAIT, ERR. Reset state is RUN; wait_cnt resets to 0.
- RUN:
  - MemReqM & ~MemReadyM -> MEM_WAIT, wait_cnt<=1.
  - Otherwise stay in RUN.
- MEM_WAIT:
  - MemReadyM -> RUN, wait_cnt<=0.
  - Else if wait_cnt==TIMEOUT -> ERR.
  - Else wait_cnt++.
  - MemReqM dropping without MemReadyM also returns to RUN (the access was squashed).
- ERR:
  - Terminal until reset. MemErr=1.
  - StallF/D/E/M=1, FlushD=FlushE=0.
- Output priority, first match wins:
  1. ERR: as above.
  2. memStall: StallF/D/E/M=1, FlushD=FlushE=0. Forwarding outputs are still computed.
  3. PCSrcE: FlushD=1, FlushE=1, all stalls 0. The redirect must load the PC, so a lwStall is dropped.
  4. lwStall: StallF=StallD=1, FlushE=1, StallE=StallM=0, FlushD=0.
  5. Otherwise all stall and flush outputs are 0.
- Counters:
  - StallCycles increments on each clock where StallF=1.
  - FlushCount increments on each clock where FlushD=1.
  - Both saturate at all-ones and reset to 0.
- During reset: MemErr=0 and counters=0. Stall and flush outputs follow the RUN decode of the current inputs.
- Reset asserted mid-MEM_WAIT or in ERR returns the FSM to RUN immediately (asynchronous).
- No x0 hazards: Rd=0 never forwards and never stalls.

Test Plan:
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10. With RegWriteM=0 -> 01. With RdM=RdW=0 -> 00.
- Load in E: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, StallCycles +1. Same with RdE=0 -> no stall.
- lwStall and PCSrcE in the same cycle -> FlushD=FlushE=1, StallF=0, FlushCount +1, StallCycles unchanged.
- MemReqM=1, MemReadyM low for 3 cycles then high -> all four stalls high for 3 cycles, state RUN->MEM_WAIT->RUN, MemErr=0, StallCycles +3.
- TIMEOUT=4, MemReqM=1, MemReadyM held 0 -> stalls for 5 cycles, then ERR: MemErr=1, stalls stuck at 1 even after MemReadyM=1. Async reset clears MemErr and counters without a clock edge.
- Force StallCycles to near-max with CNT_W=4 and hold a stall for 20 cycles -> counter saturates at 15 and does not wrap.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard/stall controller: operand forwarding, load-use and branch
// hazards, data-memory wait-state FSM with timeout trap, saturating perf counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | normal issue; memory stalls only when an access is not ready
// MEM_WAIT | data memory access outstanding, waitCnt counts wait cycles
// ERR      | access timed out; pipeline frozen until reset
module hazard_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } stateT;

  stateT          state, stateNext;
  logic [WCW-1:0] waitCnt, waitCntNext;
  logic           lwStall, memStall;

  // M stage has the younger result, so it wins over W.
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
      ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
      ForwardBE = 2'b01;
  end

  assign lwStall  = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign memStall = ((state == RUN) || (state == MEM_WAIT)) && MemReqM && !MemReadyM;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    case (state)
      RUN: begin
        if (MemReqM && !MemReadyM) begin
          stateNext   = MEM_WAIT;
          waitCntNext = WCW'(1);
        end
      end
      MEM_WAIT: begin
        // A dropped request means the access was squashed upstream.
        if (MemReadyM || !MemReqM) begin
          stateNext   = RUN;
          waitCntNext = '0;
        end else if (waitCnt == WCW'(TIMEOUT)) begin
          stateNext = ERR;
        end else begin
          waitCntNext = waitCnt + WCW'(1);
        end
      end
      ERR:     stateNext = ERR;
      default: begin
        stateNext   = RUN;
        waitCntNext = '0;
      end
    endcase
  end

  // Redirect beats load-use: the PC must take the branch target.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if ((state == ERR) || memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lwStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign MemErr = (state == ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (StallF && (StallCycles != {CNT_W{1'b1}}))
        StallCycles <= StallCycles + CNT_W'(1);
      if (FlushD && (FlushCount != {CNT_W{1'b1}}))
        FlushCount <= FlushCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios then random traffic, every cycle
// compared against a behavioural model of the hazard rules.
module tb_hazard_unit;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] StallCycles, FlushCount;
  logic sStallF, sStallD, sStallE, sStallM, sFlushD, sFlushE, sMemErr;
  logic [1:0] sFwdA, sFwdB;
  logic [3:0] sStallCycles, sFlushCount;

  int checks = 0;
  int failures = 0;

  // Model state: error flag, consecutive memory-stall cycles, event counts.
  bit mErr;
  int waitLen;
  longint stallCnt, flushCnt;

  logic [5:0] lastCtl;
  logic [1:0] lastFwdA, lastFwdB;
  logic lastErr;
  logic [31:0] lastStall, lastFlush;

  always #5 clk = ~clk;

  hazard_unit #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemErr(MemErr), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  hazard_unit #(.TIMEOUT(TO), .CNT_W(4)) dutSat (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(sStallF), .StallD(sStallD), .StallE(sStallE), .StallM(sStallM),
    .FlushD(sFlushD), .FlushE(sFlushE), .ForwardAE(sFwdA), .ForwardBE(sFwdB),
    .MemErr(sMemErr), .StallCycles(sStallCycles), .FlushCount(sFlushCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] modelFwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  function automatic logic [5:0] modelCtl(input bit errFlag);
    bit ms, lw;
    ms = MemReqM && !MemReadyM;
    lw = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (errFlag || ms) return 6'b111100;
    if (PCSrcE)        return 6'b000011;
    if (lw)            return 6'b110001;
    return 6'b000000;
  endfunction

  function automatic logic [31:0] sat4(input longint v);
    return (v > 15) ? 32'd15 : 32'(v);
  endfunction

  task automatic cycle();
    logic [5:0] exp;
    @(negedge clk);
    exp = modelCtl(mErr);
    lastCtl  = {StallF, StallD, StallE, StallM, FlushD, FlushE};
    lastFwdA = ForwardAE;
    lastFwdB = ForwardBE;
    lastErr  = MemErr;
    lastStall = StallCycles;
    lastFlush = FlushCount;
    check("ctl", 32'(lastCtl), 32'(exp));
    check("fwdA", 32'(ForwardAE), 32'(modelFwd(Rs1E)));
    check("fwdB", 32'(ForwardBE), 32'(modelFwd(Rs2E)));
    check("memErr", 32'(MemErr), 32'(mErr));
    check("stallCycles", StallCycles, 32'(stallCnt));
    check("flushCount", FlushCount, 32'(flushCnt));
    check("satCtl", 32'({sStallF, sStallD, sStallE, sStallM, sFlushD, sFlushE}), 32'(exp));
    check("satStallCycles", 32'(sStallCycles), sat4(stallCnt));
    check("satFlushCount", 32'(sFlushCount), sat4(flushCnt));
    @(posedge clk);
    if (exp[5]) stallCnt++;
    if (exp[1]) flushCnt++;
    if (!mErr) begin
      if (MemReqM && !MemReadyM) begin
        waitLen++;
        if (waitLen > TO) mErr = 1;
      end else begin
        waitLen = 0;
      end
    end
    #1;
  endtask

  // Raises reset between edges and checks the asynchronous clear before any edge.
  task automatic doReset();
    reset = 1'b1;
    #1;
    mErr = 0; waitLen = 0; stallCnt = 0; flushCnt = 0;
    check("rstMemErr", 32'(MemErr), 32'd0);
    check("rstStallCycles", StallCycles, 32'd0);
    check("rstFlushCount", FlushCount, 32'd0);
    check("rstSatStall", 32'(sStallCycles), 32'd0);
    check("rstCtl", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE}), 32'(modelCtl(0)));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic clearInputs();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM} = '0;
  endtask

  initial begin
    clearInputs();
    mErr = 0; waitLen = 0; stallCnt = 0; flushCnt = 0;
    #1;
    doReset();

    // Forwarding priority and x0 suppression
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
    cycle(); check("fwdM", 32'(lastFwdA), 32'd2);
    RegWriteM = 0;
    cycle(); check("fwdW", 32'(lastFwdA), 32'd1);
    RegWriteM = 1; RdM = 0; RdW = 0; Rs1E = 0;
    cycle(); check("fwdX0", 32'(lastFwdA), 32'd0);
    clearInputs();

    // Load-use hazard, then the same with an x0 destination
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    cycle(); check("lwStall", 32'(lastCtl), 32'b110001);
    RdE = 0;
    cycle(); check("lwX0", 32'(lastCtl), 32'd0);
    check("lwCount", lastStall, 32'd1);

    // Branch redirect overrides load-use
    RdE = 7; PCSrcE = 1;
    cycle(); check("redirect", 32'(lastCtl), 32'b000011);
    clearInputs();
    cycle(); check("redirStall", lastStall, 32'd1);
    check("redirFlush", lastFlush, 32'd1);

    // Three wait states then ready
    MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(); check("memWait", 32'(lastCtl), 32'b111100);
    end
    MemReadyM = 1;
    cycle(); check("memDone", 32'(lastCtl), 32'd0);
    check("memDoneCnt", lastStall, 32'd4);
    check("memDoneErr", 32'(lastErr), 32'd0);

    // Timeout into the error trap
    MemReadyM = 0;
    for (int i = 0; i < TO + 1; i++) begin
      cycle(); check("toStall", 32'(lastCtl), 32'b111100);
    end
    MemReadyM = 1;
    cycle(); check("errErr", 32'(lastErr), 32'd1);
    check("errCtl", 32'(lastCtl), 32'b111100);
    clearInputs();
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    doReset();
    check("rstDecode", 32'({StallF, StallD, StallE, StallM, FlushD, FlushE}), 32'b110001);
    clearInputs();

    // Squashed access returns to RUN
    MemReqM = 1;
    cycle(); cycle();
    MemReqM = 0;
    cycle(); check("squash", 32'(lastCtl), 32'd0);
    cycle();

    // Random traffic with a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      ResultSrcE0 = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      PCSrcE = ($urandom_range(0, 3) == 0);
      MemReqM = ($urandom_range(0, 2) != 0);
      MemReadyM = (i % 128 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      if (mErr && $urandom_range(0, 5) == 0) doReset();
      else cycle();
    end

    // Saturation of the narrow counter under a long stall
    clearInputs();
    doReset();
    MemReqM = 1;
    for (int i = 0; i < 20; i++) cycle();
    @(negedge clk);
    check("satNarrow", 32'(sStallCycles), 32'd15);
    check("satWide", StallCycles, 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
